ber_window_monitor: RTL and testbench

- Sits directly downstream of the BER counter stage.
- Consumes that stage's free-running 64-bit cumulative error and bit counts.
- Slices them into fixed-length measurement windows of a programmable number of bits, then reports per-window error/bit counts through a valid/ready interface.
- Raises a per-window threshold alarm, and detects upstream counter restarts (re-sync) so windows never straddle a restart.

---
 rtl/ber_window_monitor.sv | 156 +++++++++++++++
 tb/tb_ber_window_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_window_monitor.sv
// Per-window BER reporting downstream of the cumulative BER counter stage.
// Slices cumulative counts into windows and reports them over valid/ready.
module ber_window_monitor #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [63:0]      i_errors,
  input  logic [63:0]      i_bits,
  input  logic [ACC_W-1:0] i_win_len,
  input  logic [ACC_W-1:0] i_err_thr,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_win_errors,
  output logic [ACC_W-1:0] o_win_bits,
  output logic             o_alarm,
  output logic             o_overrun,
  output logic             o_resync,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_win_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [63:0]      r_prev_bits;
  logic [63:0]      r_prev_err;
  logic [ACC_W-1:0] r_acc_bits;
  logic [ACC_W-1:0] r_acc_err;
  logic [ACC_W-1:0] r_len;
  logic [ACC_W-1:0] r_thr;

  logic [63:0]      w_d_bits;
  logic [63:0]      w_d_err;
  logic [64:0]      w_sum_bits;
  logic [64:0]      w_sum_err;
  logic [ACC_W-1:0] w_nb;
  logic [ACC_W-1:0] w_ne;
  logic [ACC_W-1:0] w_len_eff;
  logic             w_regress;
  logic             w_close;
  logic             w_resync;
  logic             w_lock;

  // Deltas are modulo 2^64; a real decrease is caught by w_regress.
  always_comb begin
    w_d_bits   = i_bits - r_prev_bits;
    w_d_err    = i_errors - r_prev_err;
    w_sum_bits = 65'(r_acc_bits) + 65'(w_d_bits);
    w_sum_err  = 65'(r_acc_err) + 65'(w_d_err);
    w_nb       = (w_sum_bits > 65'(ACC_MAX))
               ? ACC_MAX : w_sum_bits[ACC_W-1:0];
    w_ne       = (w_sum_err > 65'(ACC_MAX))
               ? ACC_MAX : w_sum_err[ACC_W-1:0];
    w_len_eff  = (r_len == '0) ? ACC_ONE : r_len;
    w_regress  = (i_bits < r_prev_bits)
              || (i_errors < r_prev_err);
  end

  always_comb begin
    w_next   = r_state;
    w_close  = 1'b0;
    w_resync = 1'b0;
    w_lock   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable) w_next = S_ARM;
      end
      S_ARM: begin
        if (!i_enable) begin
          w_next = S_IDLE;
        end else if (i_bits != 64'd0) begin
          w_next = S_MEASURE;
          w_lock = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!i_enable) begin
          w_next = S_IDLE;
        end else if (w_regress) begin
          w_next   = S_ARM;
          w_resync = 1'b1;
        end else begin
          w_close = (w_nb >= w_len_eff);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_prev_bits  <= '0;
      r_prev_err   <= '0;
      r_acc_bits   <= '0;
      r_acc_err    <= '0;
      r_len        <= '0;
      r_thr        <= '0;
      o_valid      <= 1'b0;
      o_win_errors <= '0;
      o_win_bits   <= '0;
      o_alarm      <= 1'b0;
      o_overrun    <= 1'b0;
      o_resync     <= 1'b0;
      o_locked     <= 1'b0;
      o_win_count  <= '0;
    end else begin
      r_state  <= w_next;
      o_locked <= (w_next == S_MEASURE);
      o_resync <= w_resync;

      if (r_state != S_IDLE) begin
        r_prev_bits <= i_bits;
        r_prev_err  <= i_errors;
      end

      if (r_state == S_MEASURE && w_next == S_MEASURE
          && !w_close) begin
        r_acc_bits <= w_nb;
        r_acc_err  <= w_ne;
      end else begin
        r_acc_bits <= '0;
        r_acc_err  <= '0;
      end

      // Length and threshold only change at window boundaries.
      if (w_lock || w_close) begin
        r_len <= i_win_len;
        r_thr <= i_err_thr;
      end

      if (w_close) begin
        o_win_bits   <= w_nb;
        o_win_errors <= w_ne;
        o_alarm      <= (w_ne > r_thr);
        o_valid      <= 1'b1;
        o_win_count  <= o_win_count + 1'b1;
        if (o_valid && !i_ready) o_overrun <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ber_window_monitor.sv
// Directed bench for ber_window_monitor: vector table plus
// hand-written sequences for multi-cycle windows and corner cases.
module tb_ber_window_monitor;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [63:0] i_errors;
  logic [63:0] i_bits;
  logic [31:0] i_win_len;
  logic [31:0] i_err_thr;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_win_errors;
  logic [31:0] o_win_bits;
  logic        o_alarm;
  logic        o_overrun;
  logic        o_resync;
  logic        o_locked;
  logic [15:0] o_win_count;

  int pass_n = 0;
  int total_n = 0;

  ber_window_monitor #(.ACC_W(32), .CNT_W(16)) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_errors    (i_errors),
    .i_bits      (i_bits),
    .i_win_len   (i_win_len),
    .i_err_thr   (i_err_thr),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_win_errors(o_win_errors),
    .o_win_bits  (o_win_bits),
    .o_alarm     (o_alarm),
    .o_overrun   (o_overrun),
    .o_resync    (o_resync),
    .o_locked    (o_locked),
    .o_win_count (o_win_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [63:0] b;
    logic [63:0] e;
    logic [31:0] len;
    logic [31:0] thr;
    logic        rdy;
    logic        v;
    logic [31:0] wb;
    logic [31:0] we;
    logic        al;
    logic        lk;
    logic        rs;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, o_valid, 0);
    chk({tag, ".wbits"}, o_win_bits, 0);
    chk({tag, ".werr"}, o_win_errors, 0);
    chk({tag, ".alarm"}, o_alarm, 0);
    chk({tag, ".overrun"}, o_overrun, 0);
    chk({tag, ".resync"}, o_resync, 0);
    chk({tag, ".locked"}, o_locked, 0);
    chk({tag, ".count"}, o_win_count, 0);
  endtask

  initial begin
    bit close;
    bit exp_v;
    int exp_we;
    bit exp_al;

    i_reset   = 1'b1;
    i_enable  = 1'b0;
    i_errors  = '0;
    i_bits    = '0;
    i_win_len = 32'd3;
    i_err_thr = '0;
    i_ready   = 1'b1;
    do_reset();
    chk_zero("reset");

    // en b e len thr rdy | v wb we al lk rs cnt
    tv[0]  = '{1, 0, 0, 3, 0, 1,  0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 0, 3, 0, 1,  0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 1, 0, 3, 0, 1,  0, 0, 0, 0, 1, 0, 0};
    tv[3]  = '{1, 2, 0, 3, 0, 1,  0, 0, 0, 0, 1, 0, 0};
    tv[4]  = '{1, 3, 1, 3, 0, 1,  0, 0, 0, 0, 1, 0, 0};
    tv[5]  = '{1, 4, 1, 0, 1, 1,  1, 3, 1, 1, 1, 0, 1};
    tv[6]  = '{1, 5, 1, 0, 1, 1,  1, 1, 0, 0, 1, 0, 2};
    tv[7]  = '{1, 7, 3, 10, 5, 1, 1, 2, 2, 1, 1, 0, 3};
    tv[8]  = '{1, 7, 3, 10, 5, 1, 0, 2, 2, 1, 1, 0, 3};
    tv[9]  = '{1, 4, 3, 10, 5, 1, 0, 2, 2, 1, 0, 1, 3};
    tv[10] = '{1, 4, 0, 10, 5, 1, 0, 2, 2, 1, 1, 0, 3};
    tv[11] = '{1, 6, 0, 10, 5, 1, 0, 2, 2, 1, 1, 0, 3};

    for (int r = 0; r < 12; r++) begin
      i_enable  = tv[r].en;
      i_bits    = tv[r].b;
      i_errors  = tv[r].e;
      i_win_len = tv[r].len;
      i_err_thr = tv[r].thr;
      i_ready   = tv[r].rdy;
      step();
      chk($sformatf("vec%0d.valid", r), o_valid, tv[r].v);
      chk($sformatf("vec%0d.wbits", r), o_win_bits, tv[r].wb);
      chk($sformatf("vec%0d.werr", r), o_win_errors, tv[r].we);
      chk($sformatf("vec%0d.alarm", r), o_alarm, tv[r].al);
      chk($sformatf("vec%0d.locked", r), o_locked, tv[r].lk);
      chk($sformatf("vec%0d.resync", r), o_resync, tv[r].rs);
      chk($sformatf("vec%0d.count", r), o_win_count, tv[r].cnt);
      chk($sformatf("vec%0d.overrun", r), o_overrun, 0);
    end

    // Long stream: 100-bit windows, one error every 10th bit.
    i_enable = 1'b0;
    do_reset();
    i_enable  = 1'b1;
    i_win_len = 32'd100;
    i_err_thr = 32'd9;
    i_ready   = 1'b1;
    i_bits    = '0;
    i_errors  = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("prelock.locked", o_locked, 0);
      chk("prelock.valid", o_valid, 0);
    end
    for (int k = 1; k <= 5000; k++) begin
      i_bits    = 64'(k);
      i_errors  = 64'(k / 10) + ((k >= 450) ? 64'd3 : 64'd0);
      i_err_thr = (k < 150) ? 32'd9 : 32'd10;
      i_ready   = !(k >= 303 && k <= 600);
      step();
      close = (k > 1) && ((k - 1) % 100 == 0);
      exp_v = close || (k >= 401 && k <= 601);
      chk($sformatf("stream%0d.valid", k), o_valid, exp_v);
      if (k == 1) chk("stream.lock", o_locked, 1);
      if (exp_v) begin
        exp_we = (k >= 501 && k <= 600) ? 13 : 10;
        exp_al = (k == 101) || (k == 201) || (k >= 501 && k <= 600);
        chk($sformatf("stream%0d.wbits", k), o_win_bits, 100);
        chk($sformatf("stream%0d.werr", k), o_win_errors, exp_we);
        chk($sformatf("stream%0d.alarm", k), o_alarm, exp_al);
      end
      if (close)
        chk($sformatf("stream%0d.count", k), o_win_count, (k - 1) / 100);
      if (k == 500 || k == 501 || k == 601)
        chk($sformatf("stream%0d.overrun", k), o_overrun, k >= 501);
    end

    // Upstream restart mid-window.
    i_bits   = '0;
    i_errors = '0;
    step();
    chk("regress.resync", o_resync, 1);
    chk("regress.locked", o_locked, 0);
    chk("regress.valid", o_valid, 0);
    step();
    chk("regress.resync_end", o_resync, 0);
    chk("regress.locked2", o_locked, 0);
    i_ready = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      i_bits   = 64'(k);
      i_errors = 64'(k / 10);
      step();
      if (k == 1) chk("relock.locked", o_locked, 1);
      if (k == 100) chk("relock.early", o_valid, 0);
      if (k == 101) begin
        chk("relock.valid", o_valid, 1);
        chk("relock.wbits", o_win_bits, 100);
        chk("relock.werr", o_win_errors, 10);
        chk("relock.count", o_win_count, 50);
      end
    end

    // Disable mid-window with a pending report.
    i_enable = 1'b0;
    step();
    chk("disable.locked", o_locked, 0);
    chk("disable.valid", o_valid, 1);
    chk("disable.wbits", o_win_bits, 100);
    repeat (3) step();
    chk("disable.hold", o_valid, 1);
    i_ready = 1'b1;
    step();
    chk("disable.accept", o_valid, 0);

    // Zero window length behaves as one bit.
    i_win_len = '0;
    i_enable  = 1'b1;
    step();
    step();
    chk("len0.locked", o_locked, 1);
    for (int j = 1; j <= 3; j++) begin
      i_bits = 64'(110 + j);
      step();
      chk($sformatf("len0.valid%0d", j), o_valid, 1);
      chk($sformatf("len0.wbits%0d", j), o_win_bits, 1);
    end
    chk("len0.count", o_win_count, 53);
    chk("len0.overrun", o_overrun, 1);

    // Reset while measuring with a report and sticky overrun.
    i_reset = 1'b1;
    i_bits  = 64'd120;
    step();
    chk_zero("midreset");
    i_reset  = 1'b0;
    i_enable = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
